// File: rtl/dealloc_controller.sv
// Free-side engine of the dynamic memory allocator: looks up a register's block
// pointer, validates it against its size class, clears the slot bit and zeroes the pointer.
module dealloc_controller #(
    parameter int AW   = 8,
    parameter int NCLS = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              free_req,
    input  logic [2:0]        free_reg,
    input  logic [2:0]        free_cls,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [2:0]        ra_a,
    input  logic [AW-1:0]     ra_rd,
    output logic              ra_we,
    output logic [AW-1:0]     ra_wd,
    output logic [2:0]        sa_a,
    input  logic [AW-1:0]     sa_rd,
    input  logic [6*NCLS-1:0] status_in,
    output logic              st_we,
    output logic [2:0]        st_a,
    output logic [5:0]        st_wd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          state;
    logic [2:0]      reg_q;
    logic [2:0]      cls_q;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   base_q;

    logic [AW-1:0]   off;
    logic [AW-1:0]   slot;
    logic [AW-1:0]   mask;
    logic [3:0]      shamt;
    logic [5:0]      row;
    logic [5:0]      row_clr;
    logic            chk_fail;
    logic [1:0]      chk_code;

    assign ra_wd = '0;

    // Slot decode and validation on the latched pointer/base, in priority order.
    always_comb begin
        off     = addr_q - base_q;
        shamt   = {1'b0, cls_q} + 4'd1;
        slot    = off >> shamt;
        mask    = ~({AW{1'b1}} << shamt);
        row     = '0;
        for (int unsigned k = 0; k < NCLS; k++) begin
            if (cls_q == 3'(k))
                row = status_in[6*k +: 6];
        end
        row_clr  = row & ~(6'b1 << slot[2:0]);
        chk_fail = 1'b1;
        chk_code = 2'b00;
        if (cls_q >= 3'(NCLS))
            chk_code = 2'b00;
        else if ((addr_q < base_q) || (slot >= AW'(6)))
            chk_code = 2'b01;
        else if ((off & mask) != '0)
            chk_code = 2'b10;
        else if (!row[slot[2:0]])
            chk_code = 2'b11;
        else
            chk_fail = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
            ra_a     <= '0;
            sa_a     <= '0;
            st_a     <= '0;
            st_wd    <= '0;
            ra_we    <= 1'b0;
            st_we    <= 1'b0;
            reg_q    <= '0;
            cls_q    <= '0;
            addr_q   <= '0;
            base_q   <= '0;
        end else begin
            done  <= 1'b0;
            ra_we <= 1'b0;
            st_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (free_req) begin
                        reg_q    <= free_reg;
                        cls_q    <= free_cls;
                        ra_a     <= free_reg;
                        sa_a     <= free_cls;
                        err      <= 1'b0;
                        err_code <= 2'b00;
                        busy     <= 1'b1;
                        state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    addr_q <= ra_rd;
                    base_q <= sa_rd;
                    state  <= S_CHECK;
                end
                S_CHECK: begin
                    if (chk_fail) begin
                        err      <= 1'b1;
                        err_code <= chk_code;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        st_we <= 1'b1;
                        st_a  <= cls_q;
                        st_wd <= row_clr;
                        ra_we <= 1'b1;
                        ra_a  <= reg_q;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dealloc_controller.sv
// Directed bench for dealloc_controller with table models for the three stores
// and a queue of expected completions checked when done is seen.
module tb_dealloc_controller;

    localparam int AW   = 8;
    localparam int NCLS = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              free_req = 1'b0;
    logic [2:0]        free_reg = '0;
    logic [2:0]        free_cls = '0;
    logic              busy, done, err, ra_we, st_we;
    logic [1:0]        err_code;
    logic [2:0]        ra_a, sa_a, st_a;
    logic [AW-1:0]     ra_rd, ra_wd, sa_rd;
    logic [5:0]        st_wd;

    logic [AW-1:0]     ra_mem [8] = '{default: '0};
    logic [AW-1:0]     sa_mem [8];
    logic [6*NCLS-1:0] status_mem = '0;

    logic              pk_st = 1'b0;
    logic              pk_ra = 1'b0;
    logic [2:0]        pk_i = '0;
    logic [AW-1:0]     pk_v = '0;

    typedef struct {
        string      tag;
        logic       err;
        logic [1:0] code;
        logic [2:0] st_a;
        logic [5:0] st_wd;
        logic [2:0] ra_a;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    dealloc_controller #(.AW(AW), .NCLS(NCLS)) dut (
        .clk(clk), .reset(reset), .free_req(free_req), .free_reg(free_reg),
        .free_cls(free_cls), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .ra_a(ra_a), .ra_rd(ra_rd), .ra_we(ra_we),
        .ra_wd(ra_wd), .sa_a(sa_a), .sa_rd(sa_rd), .status_in(status_mem),
        .st_we(st_we), .st_a(st_a), .st_wd(st_wd)
    );

    always #5 clk = ~clk;

    assign ra_rd = ra_mem[ra_a];
    assign sa_rd = sa_mem[sa_a];

    // Store models: DUT writes plus bench-side pokes used to set up each case.
    always @(posedge clk) begin
        for (int k = 0; k < NCLS; k++) begin
            if (st_we && st_a == 3'(k)) status_mem[6*k +: 6] <= st_wd;
            if (pk_st && pk_i == 3'(k)) status_mem[6*k +: 6] <= pk_v[5:0];
        end
        if (ra_we) ra_mem[ra_a] <= ra_wd;
        if (pk_ra) ra_mem[pk_i] <= pk_v;
    end

    function automatic logic [5:0] row_of(input int k);
        return status_mem[6*k +: 6];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke_row(input int k, input logic [5:0] v);
        pk_i = 3'(k); pk_v = {2'b00, v}; pk_st = 1'b1;
        @(negedge clk);
        pk_st = 1'b0;
    endtask

    task automatic poke_ra(input int r, input logic [AW-1:0] v);
        pk_i = 3'(r); pk_v = v; pk_ra = 1'b1;
        @(negedge clk);
        pk_ra = 1'b0;
    endtask

    task automatic push(input string tag, input logic e, input logic [1:0] code,
                        input logic [2:0] sa, input logic [5:0] wd, input logic [2:0] ra);
        exp_t x;
        x.tag = tag; x.err = e; x.code = code; x.st_a = sa; x.st_wd = wd; x.ra_a = ra;
        sb.push_back(x);
    endtask

    task automatic start(input logic [2:0] r, input logic [2:0] c);
        free_reg = r; free_cls = c; free_req = 1'b1;
    endtask

    // Called at the negedge before the accepting edge; samples each following cycle.
    task automatic run(input bit hold);
        exp_t       e;
        int         done_cyc = 0;
        int         wr_cyc = 0;
        int         nwr = 0;
        bit         busy_ok = 1'b1;
        logic [1:0] we_seen = '0;
        logic [2:0] o_st_a = '0, o_ra_a = '0;
        logic [5:0] o_st_wd = '0;
        logic [AW-1:0] o_ra_wd = '0;
        for (int c = 1; c <= 12 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) free_req = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (st_we || ra_we) begin
                nwr++; wr_cyc = c; we_seen = {st_we, ra_we};
                o_st_a = st_a; o_st_wd = st_wd; o_ra_a = ra_a; o_ra_wd = ra_wd;
            end
            if (done === 1'b1) done_cyc = c;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".done_cycle"}, 64'(done_cyc), e.err ? 64'd3 : 64'd4);
        chk({e.tag, ".busy"}, 64'(busy_ok), 64'd1);
        chk({e.tag, ".err"}, 64'(err), 64'(e.err));
        chk({e.tag, ".writes"}, 64'(nwr), e.err ? 64'd0 : 64'd1);
        if (e.err) begin
            chk({e.tag, ".err_code"}, 64'(err_code), 64'(e.code));
        end else begin
            chk({e.tag, ".write_cycle"}, 64'(wr_cyc), 64'd3);
            chk({e.tag, ".both_we"}, 64'(we_seen), 64'b11);
            chk({e.tag, ".st_a"}, 64'(o_st_a), 64'(e.st_a));
            chk({e.tag, ".st_wd"}, 64'(o_st_wd), 64'(e.st_wd));
            chk({e.tag, ".ra_a"}, 64'(o_ra_a), 64'(e.ra_a));
            chk({e.tag, ".ra_wd"}, 64'(o_ra_wd), 64'd0);
        end
    endtask

    initial begin
        sa_mem[0] = 8'h20; sa_mem[1] = 8'h10; sa_mem[2] = 8'h06; sa_mem[3] = 8'h00;
        sa_mem[4] = 8'h00; sa_mem[5] = 8'h3E; sa_mem[6] = 8'h00; sa_mem[7] = 8'h00;

        #1 reset = 1'b0;
        #1;
        chk("reset_outputs",
            64'({busy, done, err, err_code, ra_we, st_we, ra_a, sa_a, st_a, st_wd}), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Good free: class 2, base 0x06, pointer 0x16 -> slot 2.
        poke_ra(3, 8'h16);
        poke_row(2, 6'b000101);
        push("good", 1'b0, 2'b00, 3'd2, 6'b000001, 3'd3);
        start(3'd3, 3'd2);
        run(1'b0);
        @(negedge clk);
        chk("good.row2", 64'(row_of(2)), 64'b000001);
        chk("good.ra3", 64'(ra_mem[3]), 64'd0);
        chk("good.idle", 64'({busy, done}), 64'd0);

        // Double free: pointer 0x0E -> slot 1 which is already clear.
        poke_ra(3, 8'h0E);
        poke_row(2, 6'b000101);
        push("dbl", 1'b1, 2'b11, 3'd0, 6'd0, 3'd0);
        start(3'd3, 3'd2);
        run(1'b0);
        @(negedge clk);
        chk("dbl.row2", 64'(row_of(2)), 64'b000101);
        chk("dbl.ra3", 64'(ra_mem[3]), 64'h0E);

        // Misaligned pointer, then err/err_code must hold while idle.
        poke_ra(3, 8'h09);
        push("misalign", 1'b1, 2'b10, 3'd0, 6'd0, 3'd0);
        start(3'd3, 3'd2);
        run(1'b0);
        @(negedge clk);
        chk("misalign.hold", 64'({done, err, err_code}), 64'b0110);
        @(negedge clk);
        chk("misalign.hold2", 64'({busy, err, err_code}), 64'b0110);

        // Below the class base, and past the last slot.
        poke_ra(3, 8'h04);
        push("below_base", 1'b1, 2'b01, 3'd0, 6'd0, 3'd0);
        start(3'd3, 3'd2);
        run(1'b0);
        poke_ra(3, 8'h36);
        push("slot6", 1'b1, 2'b01, 3'd0, 6'd0, 3'd0);
        start(3'd3, 3'd2);
        run(1'b0);
        @(negedge clk);
        chk("range.row2", 64'(row_of(2)), 64'b000101);

        // Invalid class.
        push("bad_cls", 1'b1, 2'b00, 3'd0, 6'd0, 3'd0);
        start(3'd3, 3'd6);
        run(1'b0);
        @(negedge clk);

        // Highest slot of class 3: base 0, 16-byte blocks, 0x50 -> slot 5.
        poke_ra(5, 8'h50);
        poke_row(3, 6'b100000);
        push("slot5", 1'b0, 2'b00, 3'd3, 6'b000000, 3'd5);
        start(3'd5, 3'd3);
        run(1'b0);
        @(negedge clk);
        chk("slot5.row3", 64'(row_of(3)), 64'd0);
        chk("slot5.ra5", 64'(ra_mem[5]), 64'd0);

        // Back-to-back with free_req held: class 0 slot 0 then class 5 slot 0.
        poke_ra(1, 8'h20);
        poke_ra(2, 8'h3E);
        poke_row(0, 6'b100001);
        poke_row(5, 6'b110001);
        push("b2b_first", 1'b0, 2'b00, 3'd0, 6'b100000, 3'd1);
        start(3'd1, 3'd0);
        run(1'b1);
        @(negedge clk);
        chk("b2b.gap_busy", 64'({busy, done}), 64'd0);
        push("b2b_second", 1'b0, 2'b00, 3'd5, 6'b110000, 3'd2);
        start(3'd2, 3'd5);
        run(1'b0);
        @(negedge clk);
        chk("b2b.row0", 64'(row_of(0)), 64'b100000);
        chk("b2b.row5", 64'(row_of(5)), 64'b110000);
        chk("b2b.ra", 64'({ra_mem[1], ra_mem[2]}), 64'd0);

        // Reset while the write strobes are up: nothing may land.
        poke_ra(4, 8'h14);
        poke_row(1, 6'b000010);
        start(3'd4, 3'd1);
        @(negedge clk);
        free_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid.st_we", 64'({st_we, ra_we}), 64'b11);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid.outputs",
            64'({busy, done, err, err_code, ra_we, st_we, ra_a, sa_a, st_a, st_wd}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        chk("rst_mid.row1", 64'(row_of(1)), 64'b000010);
        chk("rst_mid.ra4", 64'(ra_mem[4]), 64'h14);
        push("after_rst", 1'b0, 2'b00, 3'd1, 6'b000000, 3'd4);
        start(3'd4, 3'd1);
        run(1'b0);
        @(negedge clk);
        chk("after_rst.row1", 64'(row_of(1)), 64'd0);
        chk("after_rst.ra4", 64'(ra_mem[4]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
